uart_rx_word_ctrl: RTL and testbench
====================================

UART_RX_WORD_CTRL -- requirements
Module: uart_rx_word_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning word FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 100000, meaning idle clk cycles after which a partial word is discarded.
REQ-003 SHALL have port clk  input  1  the single clock; all state on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rdata  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rdata_ready  input  1  one-cycle pulse: rdata valid.
REQ-007 SHALL have port ferr  input  1  one-cycle pulse: framing error on the byte in flight.
REQ-008 SHALL have port flush  input  1  synchronous clear of assembler and FIFO.
REQ-009 SHALL have port clr_status  input  1  synchronous clear of sticky flags.
REQ-010 SHALL have port out_data  output  32  head word of FIFO.
REQ-011 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head when out_valid and out_ready.
REQ-013 SHALL have port word_count  output  $clog2(DEPTH)+1  words currently in FIFO.
REQ-014 SHALL have port ferr_flag  output  1  sticky: a byte was discarded due to framing error.
REQ-015 SHALL have port ovf_flag  output  1  sticky: a complete word was dropped (FIFO full).
REQ-016 SHALL have port to_flag  output  1  sticky: a partial word was discarded by timeout.

Function
REQ-017 SHALL assemble bytes little-endian: byte n (0..3) of a word into bits [8n+7:8n], tracked by a 2-bit byte counter.
REQ-018 SHALL latch a pending-error bit on a ferr pulse; it applies to the next rdata_ready (same cycle or later).
REQ-019 SHALL, on rdata_ready with ferr or pending-error set, discard the byte and any partial word, clear byte counter and pending-error, and set ferr_flag.
REQ-020 SHALL, on a good rdata_ready with byte counter 3, form the word and push it to the FIFO in the same edge; byte counter wraps to 0.
REQ-021 SHALL accept the push if FIFO not full, or if full and a pop occurs the same cycle; otherwise drop the word and set ovf_flag.
REQ-022 SHALL make out_valid high the cycle after the pushing edge when FIFO was empty (1-cycle latency); out_data is the FIFO head, stable while out_valid and not out_ready.
REQ-023 SHALL pop on out_valid and out_ready; pop on empty impossible since out_valid low.
REQ-024 SHALL keep word_count = pushes - pops, unchanged on simultaneous push and pop, range 0..DEPTH.
REQ-025 SHALL wrap read/write pointers modulo DEPTH.
REQ-026 SHALL count idle cycles while byte counter != 0, reset on every rdata_ready; at TIMEOUT discard partial word, clear byte counter, set to_flag.
REQ-027 SHALL, on flush, empty FIFO, clear byte counter, pending-error and idle counter; flush overrides push/pop in that cycle; sticky flags unchanged.
REQ-028 SHALL, on clr_status, clear all three sticky flags; a setting event in the same cycle wins (flag stays 1).
REQ-029 SHALL hold partial assembly unchanged while no rdata_ready arrives and timeout not reached.

Reset
REQ-030 SHALL, while rst high, asynchronously force: FIFO empty, pointers 0, byte counter 0, pending-error 0, idle counter 0, out_valid 0, out_data 0, word_count 0, ferr_flag 0, ovf_flag 0, to_flag 0.
REQ-031 SHALL, on rst asserted mid-word or mid-handshake, discard all content; first byte after release is byte 0.

Verification
REQ-032 SHALL verify: bytes 0x78,0x56,0x34,0x12 with out_ready=1 -> out_data 0x12345678, out_valid one cycle, word_count back to 0.
REQ-033 SHALL verify: 0xAA,0xBB then ferr+rdata_ready on 0xCC, then 0x01,0x02,0x03,0x04 -> ferr_flag=1, single word 0x04030201.
REQ-034 SHALL verify: out_ready=0, DEPTH+1 words sent -> word_count=DEPTH, ovf_flag=1, draining yields first DEPTH words in order.
REQ-035 SHALL verify: full FIFO, final byte of new word coincides with pop -> word accepted, word_count stays DEPTH, ovf_flag 0.
REQ-036 SHALL verify: TIMEOUT=16, 2 bytes then 16 idle cycles -> to_flag=1, next 4 bytes 0x11,0x22,0x33,0x44 give 0x44332211.
REQ-037 SHALL verify: rst pulsed after 3 bytes with 2 words queued -> all outputs 0, next 4 bytes form a fresh word.

Source files
------------

// File: rtl/uart_rx_word_ctrl.sv
// Assembles UART bytes into little-endian 32-bit words and queues them in a word FIFO.
// Framing errors, idle timeout and FIFO overflow are reported through sticky flags.
module uart_rx_word_ctrl #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rdata,
  input  logic                     rdata_ready,
  input  logic                     ferr,
  input  logic                     flush,
  input  logic                     clr_status,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     ferr_flag,
  output logic                     ovf_flag,
  output logic                     to_flag
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   asm_q, asm_d;
  logic          pend_q, pend_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          ferr_flag_q, ferr_flag_d;
  logic          ovf_flag_q, ovf_flag_d;
  logic          to_flag_q, to_flag_d;

  logic          push_req, push_ok, pop, full;
  logic [31:0]   push_word;
  logic          ferr_set, to_set, ovf_set;

  // Byte assembler: error discard, word completion and idle timeout
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    pend_d     = pend_q;
    idle_d     = idle_q;
    push_req   = 1'b0;
    push_word  = 32'h0;
    ferr_set   = 1'b0;
    to_set     = 1'b0;
    if (rdata_ready) begin
      idle_d = '0;
      if (ferr || pend_q) begin
        byte_cnt_d = 2'd0;
        asm_d      = '0;
        pend_d     = 1'b0;
        ferr_set   = 1'b1;
      end else begin
        case (byte_cnt_q)
          2'd0:    asm_d[7:0]   = rdata;
          2'd1:    asm_d[15:8]  = rdata;
          2'd2:    asm_d[23:16] = rdata;
          default: begin
            push_req  = 1'b1;
            push_word = {rdata, asm_q};
          end
        endcase
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end else begin
      if (ferr) pend_d = 1'b1;
      if (byte_cnt_q == 2'd0) begin
        idle_d = '0;
      end else if (idle_q == IW'(TIMEOUT - 1)) begin
        byte_cnt_d = 2'd0;
        idle_d     = '0;
        to_set     = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
    if (flush) begin
      byte_cnt_d = 2'd0;
      pend_d     = 1'b0;
      idle_d     = '0;
      push_req   = 1'b0;
      ferr_set   = 1'b0;
      to_set     = 1'b0;
    end
  end

  // Word FIFO; a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    pop      = out_valid_q & out_ready;
    full     = (count_q == CW'(DEPTH));
    push_ok  = push_req & (~full | pop);
    ovf_set  = push_req & ~push_ok;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_word;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end
    out_valid_d = (count_d != '0);
    out_data_d  = mem_d[rd_ptr_d];
  end

  // Sticky flags: a set in the same cycle beats clr_status
  always_comb begin
    ferr_flag_d = ferr_set | (ferr_flag_q & ~clr_status);
    ovf_flag_d  = ovf_set  | (ovf_flag_q  & ~clr_status);
    to_flag_d   = to_set   | (to_flag_q   & ~clr_status);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q  <= 2'd0;
      asm_q       <= '0;
      pend_q      <= 1'b0;
      idle_q      <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ferr_flag_q <= 1'b0;
      ovf_flag_q  <= 1'b0;
      to_flag_q   <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      pend_q      <= pend_d;
      idle_q      <= idle_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ferr_flag_q <= ferr_flag_d;
      ovf_flag_q  <= ovf_flag_d;
      to_flag_q   <= to_flag_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign word_count = count_q;
  assign ferr_flag  = ferr_flag_q;
  assign ovf_flag   = ovf_flag_q;
  assign to_flag    = to_flag_q;

endmodule

// File: tb/tb_uart_rx_word_ctrl.sv
// Self-checking bench for uart_rx_word_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_uart_rx_word_ctrl;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rdata = 8'h0;
  logic        rdata_ready = 1'b0;
  logic        ferr = 1'b0;
  logic        flush = 1'b0;
  logic        clr_status = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic [$clog2(DEPTH):0] word_count;
  logic        ferr_flag, ovf_flag, to_flag;

  uart_rx_word_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rdata(rdata), .rdata_ready(rdata_ready), .ferr(ferr),
    .flush(flush), .clr_status(clr_status), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .word_count(word_count), .ferr_flag(ferr_flag),
    .ovf_flag(ovf_flag), .to_flag(to_flag)
  );

  always #5 clk = ~clk;

  // Reference model state: queued words, bytes of the partial word, pending error, idle count
  logic [31:0] mq[$];
  logic [7:0]  part[$];
  bit          pend;
  int          idle;
  bit          mf, mo, mt;

  int    checks = 0;
  int    errors = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    part.delete();
    pend = 0;
    idle = 0;
    mf = 0; mo = 0; mt = 0;
  endtask

  task automatic model_step();
    bit fs = 0, os = 0, ts = 0, pop, push = 0;
    logic [31:0] w = 32'h0;
    pop = (mq.size() != 0) && out_ready;
    if (flush) begin
      mq.delete();
      part.delete();
      pend = 0;
      idle = 0;
    end else begin
      if (rdata_ready) begin
        idle = 0;
        if (ferr || pend) begin
          part.delete();
          pend = 0;
          fs = 1;
        end else begin
          part.push_back(rdata);
          if (part.size() == 4) begin
            w = {part[3], part[2], part[1], part[0]};
            part.delete();
            push = 1;
          end
        end
      end else begin
        if (ferr) pend = 1;
        if (part.size() == 0) idle = 0;
        else begin
          idle++;
          if (idle >= TO) begin
            part.delete();
            idle = 0;
            ts = 1;
          end
        end
      end
      if (pop) mq.delete(0);
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(w);
        else os = 1;
      end
    end
    mf = fs | (mf & !clr_status);
    mo = os | (mo & !clr_status);
    mt = ts | (mt & !clr_status);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("valid", 32'(out_valid), 32'(mq.size() != 0));
    check("count", 32'(word_count), 32'(mq.size()));
    check("ferr_flag", 32'(ferr_flag), 32'(mf));
    check("ovf_flag", 32'(ovf_flag), 32'(mo));
    check("to_flag", 32'(to_flag), 32'(mt));
    if (mq.size() != 0) check("head", out_data, mq[0]);
  endtask

  task automatic drive(input bit rr, input logic [7:0] d, input bit fe, input bit ordy,
                       input bit fl, input bit cs);
    rdata_ready = rr; rdata = d; ferr = fe; out_ready = ordy; flush = fl; clr_status = cs;
    step();
    rdata_ready = 0; ferr = 0; flush = 0; clr_status = 0;
  endtask

  task automatic idle_cycles(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(0, 8'h0, 0, ordy, 0, 0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit ordy);
    for (int i = 0; i < 4; i++) drive(1, w[8*i +: 8], 0, ordy, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_count", 32'(word_count), 32'h0);
    check("rst_flags", {29'h0, ferr_flag, ovf_flag, to_flag}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] sent [DEPTH+1];

  initial begin
    model_reset();
    phase = "reset";
    do_reset();

    phase = "basic";
    drive(1, 8'h78, 0, 1, 0, 0);
    drive(1, 8'h56, 0, 1, 0, 0);
    drive(1, 8'h34, 0, 1, 0, 0);
    drive(1, 8'h12, 0, 1, 0, 0);
    check("basic_data", out_data, 32'h12345678);
    check("basic_valid", 32'(out_valid), 32'h1);
    idle_cycles(1, 1);
    check("basic_valid_off", 32'(out_valid), 32'h0);
    check("basic_count", 32'(word_count), 32'h0);

    phase = "ferr";
    drive(1, 8'hAA, 0, 0, 0, 0);
    drive(1, 8'hBB, 0, 0, 0, 0);
    drive(1, 8'hCC, 1, 0, 0, 0);
    check("ferr_set", 32'(ferr_flag), 32'h1);
    send_word(32'h04030201, 0);
    check("ferr_count", 32'(word_count), 32'h1);
    check("ferr_word", out_data, 32'h04030201);
    idle_cycles(1, 1);
    check("ferr_drained", 32'(word_count), 32'h0);

    phase = "pend";
    drive(1, 8'h10, 0, 0, 0, 0);
    drive(0, 8'h00, 1, 0, 0, 0);
    idle_cycles(2, 0);
    drive(1, 8'h20, 0, 0, 0, 1);
    check("pend_flag_wins", 32'(ferr_flag), 32'h1);
    drive(0, 8'h00, 0, 0, 0, 1);
    check("pend_cleared", 32'(ferr_flag), 32'h0);
    send_word(32'hCAFEF00D, 1);
    check("pend_word", out_data, 32'hCAFEF00D);
    idle_cycles(1, 1);

    phase = "ovf";
    for (int i = 0; i <= DEPTH; i++) begin
      sent[i] = $urandom;
      send_word(sent[i], 0);
    end
    check("ovf_count", 32'(word_count), 32'(DEPTH));
    check("ovf_flag", 32'(ovf_flag), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_order", out_data, sent[i]);
      idle_cycles(1, 1);
    end
    check("ovf_empty", 32'(word_count), 32'h0);

    phase = "full_pop";
    drive(0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i <= DEPTH; i++) sent[i] = $urandom;
    for (int i = 0; i < DEPTH; i++) send_word(sent[i], 0);
    for (int i = 0; i < 3; i++) drive(1, sent[DEPTH][8*i +: 8], 0, 0, 0, 0);
    drive(1, sent[DEPTH][31:24], 0, 1, 0, 0);
    check("fp_count", 32'(word_count), 32'(DEPTH));
    check("fp_ovf", 32'(ovf_flag), 32'h0);
    for (int i = 1; i <= DEPTH; i++) begin
      check("fp_order", out_data, sent[i]);
      idle_cycles(1, 1);
    end

    phase = "timeout";
    drive(0, 8'h00, 0, 0, 1, 0);
    drive(1, 8'hEE, 0, 0, 0, 0);
    drive(1, 8'hDD, 0, 0, 0, 0);
    idle_cycles(TO - 1, 0);
    check("to_early", 32'(to_flag), 32'h0);
    idle_cycles(1, 0);
    check("to_set", 32'(to_flag), 32'h1);
    send_word(32'h44332211, 0);
    check("to_word", out_data, 32'h44332211);
    idle_cycles(1, 1);

    phase = "midreset";
    send_word($urandom, 0);
    send_word($urandom, 0);
    drive(1, 8'h01, 0, 0, 0, 0);
    drive(1, 8'h02, 0, 0, 0, 0);
    drive(1, 8'h03, 0, 0, 0, 0);
    do_reset();
    send_word(32'hD4C3B2A1, 0);
    check("mr_word", out_data, 32'hD4C3B2A1);
    check("mr_count", 32'(word_count), 32'h1);

    phase = "random";
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 50; i++) begin
        drive(bit'($urandom_range(0, 2) != 0), 8'($urandom), bit'($urandom_range(0, 19) == 0),
              bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 99) == 0),
              bit'($urandom_range(0, 29) == 0));
      end
      idle_cycles(TO + 2, bit'(blk[0]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
